// File: rtl/nco_ctrl_pkg.sv
// Shared types and default sizing for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int unsigned FCW_W_DEF     = 20;
    localparam int unsigned DW_DEF        = 12;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned FLUSH_CYC_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/nco_fcw_stepper.sv
// FCW accumulator and step index counter for the frequency sweep.
module nco_fcw_stepper #(
    parameter int unsigned FCW_W = 20,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [FCW_W-1:0] i_fcw_start,
    input  logic [FCW_W-1:0] i_fcw_step,
    input  logic [CNT_W-1:0] i_num_steps,
    input  logic             i_adv,
    output logic [FCW_W-1:0] o_fcw,
    output logic [CNT_W-1:0] o_step_idx,
    output logic             o_last_c
);

    logic [FCW_W-1:0] r_fcw;
    logic [FCW_W-1:0] r_fcw_step;
    logic [CNT_W-1:0] r_num_steps;
    logic [CNT_W-1:0] r_step_idx;

    // Load sweep origin on start, advance one step (modular add) on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcw       <= '0;
            r_fcw_step  <= '0;
            r_num_steps <= '0;
            r_step_idx  <= '0;
        end else if (i_load) begin
            r_fcw       <= i_fcw_start;
            r_fcw_step  <= i_fcw_step;
            r_num_steps <= i_num_steps;
            r_step_idx  <= '0;
        end else if (i_adv) begin
            r_fcw       <= r_fcw + r_fcw_step;
            r_step_idx  <= r_step_idx + CNT_W'(1);
        end
    end

    assign o_fcw      = r_fcw;
    assign o_step_idx = r_step_idx;
    // Only consulted while a sweep with num_steps >= 1 is active.
    assign o_last_c   = (r_step_idx == r_num_steps - CNT_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the CORDIC NCO control inputs.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned FCW_W     = FCW_W_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FCW_W-1:0] cfg_fcw_start,
    input  logic [FCW_W-1:0] cfg_fcw_step,
    input  logic [CNT_W-1:0] cfg_num_steps,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic             cfg_sel_xy,
    input  logic             cfg_sel_sign,
    output logic             nco_en,
    output logic [FCW_W-1:0] nco_fcw,
    output logic             nco_sel_xy,
    output logic             nco_sel_sign,
    input  logic             nco_vld,
    input  logic [DW-1:0]    nco_dout,
    output logic             smp_valid,
    output logic [DW-1:0]    smp_data,
    output logic [CNT_W-1:0] smp_step,
    output logic             smp_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_smp_cnt;
    logic [FL_W-1:0]  r_flush_cnt;

    logic             w_load;
    logic             w_adv;
    logic             w_last_step;
    logic             w_dwell_end;
    logic [CNT_W-1:0] w_step_idx;

    assign w_dwell_end = (r_smp_cnt == r_dwell - CNT_W'(1));
    assign w_load      = (r_state == ST_IDLE) && start && !abort;
    assign w_adv       = (r_state == ST_RUN) && !abort && nco_vld && w_dwell_end && !w_last_step;

    nco_fcw_stepper #(
        .FCW_W (FCW_W),
        .CNT_W (CNT_W)
    ) u_stepper (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_fcw_start (cfg_fcw_start),
        .i_fcw_step  (cfg_fcw_step),
        .i_num_steps (cfg_num_steps),
        .i_adv       (w_adv),
        .o_fcw       (nco_fcw),
        .o_step_idx  (w_step_idx),
        .o_last_c    (w_last_step)
    );

    // Sweep FSM with flush/sample counters; outputs track the state they enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dwell      <= '0;
            r_smp_cnt    <= '0;
            r_flush_cnt  <= '0;
            nco_en       <= 1'b0;
            nco_sel_xy   <= 1'b0;
            nco_sel_sign <= 1'b0;
            smp_valid    <= 1'b0;
            smp_data     <= '0;
            smp_step     <= '0;
            smp_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            smp_valid <= 1'b0;
            smp_last  <= 1'b0;
            done      <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                nco_en  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_dwell      <= cfg_dwell;
                            nco_sel_xy   <= cfg_sel_xy;
                            nco_sel_sign <= cfg_sel_sign;
                            if ((cfg_num_steps == '0) || (cfg_dwell == '0)) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_LOAD;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= '0;
                        nco_en      <= 1'b1;
                    end
                    ST_FLUSH: begin
                        if (r_flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                            r_state   <= ST_RUN;
                            r_smp_cnt <= '0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + FL_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (nco_vld) begin
                            smp_valid <= 1'b1;
                            smp_data  <= nco_dout;
                            smp_step  <= w_step_idx;
                            r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                            if (w_dwell_end) begin
                                nco_en <= 1'b0;
                                if (w_last_step) begin
                                    smp_last <= 1'b1;
                                    busy     <= 1'b0;
                                    r_state  <= ST_DONE;
                                end else begin
                                    r_state  <= ST_LOAD;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        nco_en  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: cycle model plus sample scoreboard.
module tb_nco_sweep_ctrl;

    localparam int FCW_W = 20;
    localparam int DW    = 12;
    localparam int CNT_W = 16;
    localparam int FC    = nco_ctrl_pkg::FLUSH_CYC_DEF;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_RUN   = 3;
    localparam int M_DONE  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [FCW_W-1:0] cfg_fcw_start = '0;
    logic [FCW_W-1:0] cfg_fcw_step = '0;
    logic [CNT_W-1:0] cfg_num_steps = '0;
    logic [CNT_W-1:0] cfg_dwell = '0;
    logic             cfg_sel_xy = 1'b0;
    logic             cfg_sel_sign = 1'b0;
    logic             nco_en;
    logic [FCW_W-1:0] nco_fcw;
    logic             nco_sel_xy;
    logic             nco_sel_sign;
    logic             nco_vld = 1'b0;
    logic [DW-1:0]    nco_dout = '0;
    logic             smp_valid;
    logic [DW-1:0]    smp_data;
    logic [CNT_W-1:0] smp_step;
    logic             smp_last;
    logic             busy;
    logic             done;

    nco_sweep_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_fcw_start (cfg_fcw_start),
        .cfg_fcw_step  (cfg_fcw_step),
        .cfg_num_steps (cfg_num_steps),
        .cfg_dwell     (cfg_dwell),
        .cfg_sel_xy    (cfg_sel_xy),
        .cfg_sel_sign  (cfg_sel_sign),
        .nco_en        (nco_en),
        .nco_fcw       (nco_fcw),
        .nco_sel_xy    (nco_sel_xy),
        .nco_sel_sign  (nco_sel_sign),
        .nco_vld       (nco_vld),
        .nco_dout      (nco_dout),
        .smp_valid     (smp_valid),
        .smp_data      (smp_data),
        .smp_step      (smp_step),
        .smp_last      (smp_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [11:0] d;
        int          s;
        bit          l;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model of the sweep, advanced once per cycle.
    int               m_st;
    logic [FCW_W-1:0] m_fcw;
    logic [FCW_W-1:0] m_stepv;
    int               m_step, m_nsteps, m_dwell, m_flush, m_cnt;
    bit               m_sel_xy, m_sel_sign, exp_done;

    // Per-test observations.
    int n_smp, start_cyc, first_cyc, done_cyc;
    bit saw_en, saw_busy, saw_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_fcw = '0; m_stepv = '0; m_step = 0; m_nsteps = 0;
        m_dwell = 0; m_flush = 0; m_cnt = 0; m_sel_xy = 0; m_sel_sign = 0;
        exp_done = 0;
        q.delete();
    endtask

    task automatic obs_reset();
        n_smp = 0; start_cyc = -1; first_cyc = -1; done_cyc = -1;
        saw_en = 0; saw_busy = 0; saw_done = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    // mode: 0 = vld low, 1 = vld high, 2 = vld high in FLUSH and every 3rd cycle otherwise.
    task automatic tick(input bit st, input bit ab, input int mode);
        bit   v;
        exp_t e;
        bit   dnext;
        @(posedge clk);
        #1;
        v = (mode == 1) || ((mode == 2) && ((m_st == M_FLUSH) || (cyc % 3 == 0)));
        start    = st;
        abort    = ab;
        nco_vld  = v;
        nco_dout = 12'($urandom_range(0, 4095));
        @(negedge clk);
        chk("nco_en", nco_en, (m_st == M_FLUSH) || (m_st == M_RUN));
        chk("busy", busy, (m_st == M_LOAD) || (m_st == M_FLUSH) || (m_st == M_RUN));
        chk("nco_fcw", nco_fcw, m_fcw);
        chk("nco_sel", {nco_sel_xy, nco_sel_sign}, {m_sel_xy, m_sel_sign});
        chk("done", done, exp_done);
        saw_en   |= nco_en;
        saw_busy |= busy;
        saw_done |= done;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (smp_valid) begin
            n_smp++;
            if (first_cyc < 0) first_cyc = cyc;
            if (q.size() == 0) begin
                chk("smp_spurious", 1, 0);
            end else begin
                e = q.pop_front();
                chk("smp_cycle", cyc, e.c);
                chk("smp_data", smp_data, e.d);
                chk("smp_step", smp_step, e.s);
                chk("smp_last", smp_last, e.l);
            end
        end else begin
            chk("smp_last_idle", smp_last, 0);
            if (q.size() > 0 && q[0].c <= cyc) begin
                chk("smp_missing", 0, 1);
                void'(q.pop_front());
            end
        end
        // Advance the model using this cycle's inputs.
        dnext = (m_st == M_DONE) && !ab;
        if (st && m_st == M_IDLE && !ab) start_cyc = cyc;
        if (ab && m_st != M_IDLE) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (st && !ab) begin
                    m_fcw = cfg_fcw_start; m_stepv = cfg_fcw_step;
                    m_nsteps = int'(cfg_num_steps); m_dwell = int'(cfg_dwell);
                    m_sel_xy = cfg_sel_xy; m_sel_sign = cfg_sel_sign; m_step = 0;
                    m_st = (m_nsteps == 0 || m_dwell == 0) ? M_DONE : M_LOAD;
                end
                M_LOAD: begin m_st = M_FLUSH; m_flush = 0; end
                M_FLUSH: begin
                    m_flush++;
                    if (m_flush == FC) begin m_st = M_RUN; m_cnt = 0; end
                end
                M_RUN: if (v) begin
                    m_cnt++;
                    e.c = cyc + 1; e.d = nco_dout; e.s = m_step;
                    e.l = (m_cnt == m_dwell) && (m_step == m_nsteps - 1);
                    q.push_back(e);
                    if (m_cnt == m_dwell) begin
                        if (e.l) m_st = M_DONE;
                        else begin
                            m_step++; m_fcw = m_fcw + m_stepv; m_st = M_LOAD;
                        end
                    end
                end
                M_DONE: m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
        exp_done = dnext;
    endtask

    // Run until the model is idle with no done pending or sample outstanding.
    task automatic run_idle(input int mode);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (m_st == M_IDLE && !exp_done && q.size() == 0) break;
            tick(0, 0, mode);
        end
        if (i == 3000) chk("timeout", 0, 1);
        tick(0, 0, 0);
    endtask

    task automatic run_to_run(input int cnt_target, input int mode);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (m_st == M_RUN && m_cnt == cnt_target) break;
            tick(0, 0, mode);
        end
        if (i == 3000) chk("timeout_run", 0, 1);
    endtask

    task automatic set_cfg(input logic [FCW_W-1:0] fs, input logic [FCW_W-1:0] fst,
                           input int ns, input int dw, input bit sx, input bit ss);
        cfg_fcw_start = fs; cfg_fcw_step = fst;
        cfg_num_steps = CNT_W'(ns); cfg_dwell = CNT_W'(dw);
        cfg_sel_xy = sx; cfg_sel_sign = ss;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, nco_en, 0);
        chk({tag, "_fcw"}, nco_fcw, 0);
        chk({tag, "_sel"}, {nco_sel_xy, nco_sel_sign}, 0);
        chk({tag, "_smp"}, {smp_valid, smp_last}, 0);
        chk({tag, "_data"}, smp_data, 0);
        chk({tag, "_step"}, smp_step, 0);
        chk({tag, "_busy_done"}, {busy, done}, 0);
    endtask

    initial begin
        model_reset();
        obs_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 0);

        // Basic sweep: 3 steps x 4 samples.
        set_cfg(20'h01000, 20'h00800, 3, 4, 1, 0);
        obs_reset();
        tick(1, 0, 1);
        run_idle(1);
        chk("basic_count", n_smp, 12);
        chk("basic_latency", first_cyc - start_cyc, 2 + FC + 1);
        chk("basic_final_fcw", nco_fcw, 20'h02000);
        chk("basic_done_seen", saw_done, 1);

        // Wrap on positive step.
        set_cfg(20'hFFC00, 20'h00800, 2, 1, 0, 1);
        obs_reset();
        tick(1, 0, 1);
        run_idle(1);
        chk("wrap_fcw", nco_fcw, 20'h00400);
        chk("wrap_count", n_smp, 2);

        // Negative step.
        set_cfg(20'h00400, 20'hFF800, 2, 1, 1, 1);
        obs_reset();
        tick(1, 0, 1);
        run_idle(1);
        chk("neg_fcw", nco_fcw, 20'hFFC00);

        // Flush masking with sparse valid in RUN.
        set_cfg(20'h12345, 20'h00010, 2, 2, 0, 0);
        obs_reset();
        tick(1, 0, 2);
        run_idle(2);
        chk("sparse_count", n_smp, 4);

        // Degenerate: zero steps, then zero dwell.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_cfg(20'h00111, 20'h00001, 0, 3, 1, 0);
            else        set_cfg(20'h00222, 20'h00001, 2, 0, 0, 1);
            obs_reset();
            tick(1, 0, 1);
            run_idle(1);
            tick(0, 0, 1);
            chk("degen_done_lat", done_cyc - start_cyc, 2);
            chk("degen_no_en", saw_en, 0);
            chk("degen_no_busy", saw_busy, 0);
            chk("degen_no_smp", n_smp, 0);
        end

        // Abort mid-RUN with a sample arriving in the abort cycle.
        set_cfg(20'h01000, 20'h00800, 3, 4, 1, 1);
        obs_reset();
        tick(1, 0, 1);
        run_to_run(2, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_en", nco_en, 0);
        repeat (4) tick(0, 0, 1);
        chk("abort_smp", n_smp, 2);
        chk("abort_no_done", saw_done, 0);
        chk("abort_fcw_hold", nco_fcw, 20'h01000);
        obs_reset();
        tick(1, 0, 1);
        run_idle(1);
        chk("post_abort_count", n_smp, 12);
        chk("post_abort_fcw", nco_fcw, 20'h02000);

        // Start during RUN and cfg changes while busy are ignored.
        set_cfg(20'h01000, 20'h00800, 3, 4, 0, 1);
        obs_reset();
        tick(1, 0, 1);
        run_to_run(1, 1);
        set_cfg(20'hAAAAA, 20'h11111, 1, 1, 1, 0);
        tick(1, 0, 1);
        run_idle(1);
        chk("ign_count", n_smp, 12);
        chk("ign_fcw", nco_fcw, 20'h02000);
        chk("ign_sel", {nco_sel_xy, nco_sel_sign}, 2'b01);

        // start and abort together in IDLE: stays idle.
        obs_reset();
        tick(1, 1, 1);
        repeat (4) tick(0, 0, 1);
        chk("conflict_busy", saw_busy, 0);
        chk("conflict_done", saw_done, 0);

        // Asynchronous reset mid-sweep.
        set_cfg(20'h05555, 20'h00100, 3, 4, 1, 1);
        obs_reset();
        tick(1, 0, 1);
        run_to_run(1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0; abort = 1'b0; nco_vld = 1'b0;
        repeat (3) tick(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
